button_press_array: RTL and testbench

Parametrised, multi-channel successor to the single-button press detector that feeds the pet's action inputs (feed, play, light, sound, test).
- Each channel: synchronises a raw board button, debounces it against a shared tick enable, and classifies the activity as press, short press, long press or auto-repeat.
- Runs on the main system clock, so downstream FSMs receive single-cycle pulses in the clk domain; no generated clocks.

---
 rtl/button_press_array.sv | 151 +++++++++++++++
 tb/tb_button_press_array.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/button_press_array.sv
// Multi-channel button front end: synchronise, debounce against a shared tick,
// and classify each channel's activity as press / short / long / auto-repeat pulses.
module button_press_array #(
  parameter int N_BTN        = 5,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int DEB_TICKS    = 20,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 250,
  parameter int CNT_W        = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] short_press,
  output logic [N_BTN-1:0] long_press,
  output logic [N_BTN-1:0] repeat_p,
  output logic             any_press
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_TICKS - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);
  localparam bit               REP_EN    = (REPEAT_TICKS != 0);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG
  } state_t;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic             sync1;
    logic             sync2;
    logic             level_n;
    logic             stable;
    logic             stable_q;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] rep_cnt;
    state_t           state;
    logic             press_r;
    logic             short_r;
    logic             long_r;
    logic             rep_r;

    // Synchronisers reset to the raw "released" level so reset never looks like a press.
    always_ff @(posedge clk) begin
      if (!rst) begin
        sync1 <= ACTIVE_LOW;
        sync2 <= ACTIVE_LOW;
      end else begin
        sync1 <= btn_in[i];
        sync2 <= sync1;
      end
    end

    assign level_n = ACTIVE_LOW ? ~sync2 : sync2;

    always_ff @(posedge clk) begin
      if (!rst) begin
        stable   <= 1'b0;
        stable_q <= 1'b0;
        deb_cnt  <= '0;
      end else begin
        stable_q <= stable;
        if (level_n == stable) begin
          deb_cnt <= '0;
        end else if (tick) begin
          if (deb_cnt == DEB_LAST) begin
            stable  <= level_n;
            deb_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + ONE;
          end
        end
      end
    end

    assign rise = stable & ~stable_q;
    assign fall = ~stable & stable_q;

    // A release is checked before any tick threshold so it always wins the cycle.
    always_ff @(posedge clk) begin
      if (!rst) begin
        state    <= IDLE;
        hold_cnt <= '0;
        rep_cnt  <= '0;
        press_r  <= 1'b0;
        short_r  <= 1'b0;
        long_r   <= 1'b0;
        rep_r    <= 1'b0;
      end else begin
        press_r <= 1'b0;
        short_r <= 1'b0;
        long_r  <= 1'b0;
        rep_r   <= 1'b0;
        case (state)
          IDLE: begin
            if (rise) begin
              press_r  <= 1'b1;
              hold_cnt <= '0;
              state    <= PRESSED;
            end
          end
          PRESSED: begin
            if (fall) begin
              short_r <= 1'b1;
              state   <= IDLE;
            end else if (tick) begin
              if (hold_cnt == LONG_LAST) begin
                long_r  <= 1'b1;
                rep_cnt <= '0;
                state   <= LONG;
              end else begin
                hold_cnt <= hold_cnt + ONE;
              end
            end
          end
          LONG: begin
            if (fall) begin
              state <= IDLE;
            end else if (tick && REP_EN) begin
              if (rep_cnt == REP_LAST) begin
                rep_r   <= 1'b1;
                rep_cnt <= '0;
              end else begin
                rep_cnt <= rep_cnt + ONE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign btn_level[i]   = stable;
    assign press[i]       = press_r;
    assign short_press[i] = short_r;
    assign long_press[i]  = long_r;
    assign repeat_p[i]    = rep_r;
  end

  assign any_press = |press;

endmodule

// File: tb/tb_button_press_array.sv
// Directed bench for button_press_array: table of tick-aligned phases with expected
// pulse counts, plus hand sequences for exact latency and reset during a long hold.
module tb_button_press_array;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [1:0] btn_in;
  logic [1:0] btn_level;
  logic [1:0] press;
  logic [1:0] short_press;
  logic [1:0] long_press;
  logic [1:0] repeat_p;
  logic       any_press;

  always #5 clk = ~clk;

  button_press_array #(
    .N_BTN(2), .ACTIVE_LOW(1'b1), .DEB_TICKS(4), .LONG_TICKS(10),
    .REPEAT_TICKS(3), .CNT_W(12)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_in(btn_in),
    .btn_level(btn_level), .press(press), .short_press(short_press),
    .long_press(long_press), .repeat_p(repeat_p), .any_press(any_press)
  );

  typedef struct {
    logic [1:0] btn;
    int         ticks;
    logic [1:0] level;
    int p0, p1, s0, s1, l0, l1, r0, r1, an;
  } vec_t;

  vec_t vecs[$];

  int checks = 0;
  int errors = 0;
  int tcnt = 0;
  int sidx;
  int first_level;
  int first_press;
  int viol;
  int cp[2];
  int cs[2];
  int cl[2];
  int cr[2];
  int ca;

  function automatic vec_t mk(input logic [1:0] b, input int t, input logic [1:0] lv,
                              input int p0, input int p1, input int s0, input int s1,
                              input int l0, input int l1, input int r0, input int r1,
                              input int an);
    vec_t v;
    v.btn = b; v.ticks = t; v.level = lv;
    v.p0 = p0; v.p1 = p1; v.s0 = s0; v.s1 = s1;
    v.l0 = l0; v.l1 = l1; v.r0 = r0; v.r1 = r1; v.an = an;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic clear_counts();
    sidx = 0;
    first_level = -1;
    first_press = -1;
    ca = 0;
    for (int c = 0; c < 2; c++) begin
      cp[c] = 0; cs[c] = 0; cl[c] = 0; cr[c] = 0;
    end
  endtask

  // One clk: sample outputs at the falling edge, then drive tick for the next rising edge.
  task automatic clock_step();
    @(negedge clk);
    sidx++;
    for (int c = 0; c < 2; c++) begin
      cp[c] += int'(press[c]);
      cs[c] += int'(short_press[c]);
      cl[c] += int'(long_press[c]);
      cr[c] += int'(repeat_p[c]);
      if (int'(press[c]) + int'(short_press[c]) + int'(long_press[c]) + int'(repeat_p[c]) > 1)
        viol++;
    end
    ca += int'(any_press);
    if (any_press !== |press) viol++;
    if (first_level < 0 && btn_level[0] === 1'b1) first_level = sidx;
    if (first_press < 0 && press[0] === 1'b1) first_press = sidx;
    tick = (tcnt == 3);
    tcnt = (tcnt + 1) % 4;
  endtask

  task automatic applyStimulus(input logic [1:0] b, input int nsteps);
    btn_in = b;
    for (int k = 0; k < nsteps; k++) clock_step();
  endtask

  initial begin
    rst = 1'b0;
    tick = 1'b0;
    btn_in = 2'b00;
    viol = 0;
    clear_counts();

    repeat (3) clock_step();
    checkOutput("reset btn_level", int'(btn_level), 0);
    checkOutput("reset press", int'(press), 0);
    checkOutput("reset short_press", int'(short_press), 0);
    checkOutput("reset long_press", int'(long_press), 0);
    checkOutput("reset repeat_p", int'(repeat_p), 0);
    checkOutput("reset any_press", int'(any_press), 0);

    rst = 1'b1;
    btn_in = 2'b11;
    do clock_step(); while (tcnt != 0);
    viol = 0;

    // Every phase is a whole number of ticks and starts on the clk whose tick is asserted.
    vecs.push_back(mk(2'b11, 6, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2'b10, 6, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(2'b11, 6, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int b = 0; b < 10; b++)
      vecs.push_back(mk((b % 2 == 0) ? 2'b10 : 2'b11, 2, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2'b11, 6, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2'b01, 25, 2'b10, 0, 1, 0, 0, 0, 1, 0, 3, 1));
    vecs.push_back(mk(2'b11, 6, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2, 0));
    vecs.push_back(mk(2'b00, 6, 2'b11, 1, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(2'b11, 6, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      clear_counts();
      applyStimulus(vecs[i].btn, vecs[i].ticks * 4);
      checkOutput($sformatf("v%0d btn_level", i), int'(btn_level), int'(vecs[i].level));
      checkOutput($sformatf("v%0d press0", i), cp[0], vecs[i].p0);
      checkOutput($sformatf("v%0d press1", i), cp[1], vecs[i].p1);
      checkOutput($sformatf("v%0d short0", i), cs[0], vecs[i].s0);
      checkOutput($sformatf("v%0d short1", i), cs[1], vecs[i].s1);
      checkOutput($sformatf("v%0d long0", i), cl[0], vecs[i].l0);
      checkOutput($sformatf("v%0d long1", i), cl[1], vecs[i].l1);
      checkOutput($sformatf("v%0d repeat0", i), cr[0], vecs[i].r0);
      checkOutput($sformatf("v%0d repeat1", i), cr[1], vecs[i].r1);
      checkOutput($sformatf("v%0d any_press", i), ca, vecs[i].an);
    end

    // Exact latency: 2 clk of sync, 4 counted ticks, level then press one clk later.
    clear_counts();
    applyStimulus(2'b10, 24);
    checkOutput("latency level clk", first_level, 17);
    checkOutput("latency press clk", first_press, 18);
    checkOutput("latency press count", cp[0], 1);
    clear_counts();
    applyStimulus(2'b11, 24);
    checkOutput("latency short count", cs[0], 1);
    checkOutput("latency long count", cl[0], 0);

    // Reset in the middle of a long hold, button still held down afterwards.
    clear_counts();
    applyStimulus(2'b10, 64);
    checkOutput("midhold long0", cl[0], 1);
    checkOutput("midhold repeat0", cr[0], 0);
    checkOutput("midhold level0", int'(btn_level[0]), 1);
    rst = 1'b0;
    clear_counts();
    clock_step();
    rst = 1'b1;
    checkOutput("midhold rst btn_level", int'(btn_level), 0);
    checkOutput("midhold rst pulses",
                int'({press, short_press, long_press, repeat_p, any_press}), 0);
    for (int k = 0; k < 29; k++) clock_step();
    checkOutput("midhold re-level clk", first_level, 17);
    checkOutput("midhold re-press clk", first_press, 18);
    checkOutput("midhold re-press count", cp[0], 1);
    checkOutput("midhold no short", cs[0], 0);
    clear_counts();
    applyStimulus(2'b11, 24);
    checkOutput("midhold release short", cs[0], 1);
    checkOutput("midhold release long", cl[0], 0);

    checkOutput("pulse exclusivity", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
